// File: rtl/gate_checker.sv
// gate_checker -- built-in self test for a 2-input combinational gate.
//
// On a start request the block walks the operand pair {a,b} through
// 00, 01, 10, 11, holding each vector for SETTLE+1 cycles. On the last
// rising edge of each window it compares the gate response c against
// EXPECT[{a,b}], counting mismatches (saturating at 7) and remembering the
// first failing vector. A one-cycle done pulse closes the sequence and pass
// reports whether that sequence was clean.
//
// Parameters:
//   SETTLE   extra hold cycles per vector before c is sampled (0..15)
//   EXPECT   expected truth table indexed by {a,b} (default XOR)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   level request; sampled only in IDLE
//   c         in   response of the gate under test
//   a, b      out  registered stimulus operands
//   busy      out  high while vectors are being driven and sampled
//   done      out  one-cycle pulse at sequence completion
//   pass      out  last completed sequence had zero mismatches
//   err_cnt   out  mismatch count, saturating at 7
//   fail_vec  out  {a,b} of the first mismatch, 0 if none
//
// Build option:
//   GATE_CHECKER_LOOP_EN  when defined, start held high in DONE re-enters
//                         DRIVE directly; the error count keeps accumulating
//                         until the next restart from IDLE.

module gate_checker #(
    parameter int unsigned SETTLE = 1,
    parameter logic [3:0]  EXPECT = 4'b0110
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       c,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [1:0] fail_vec
);

    localparam logic [3:0] WIN_LAST = SETTLE[3:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [1:0] vec, vec_nx;
    logic [3:0] win, win_nx;
    logic       a_q, b_q;

    logic [2:0] err_q, err_nx;
    logic [1:0] fv_q, fv_nx;
    logic       seen_q, seen_nx;
    logic       pass_q, pass_nx;
    logic       sample, mismatch;

    // ------------------------------------------------------------------
    // State register (also holds the registered a/b and result flops)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            vec    <= '0;
            win    <= '0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            err_q  <= '0;
            fv_q   <= '0;
            seen_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_nx;
            vec    <= vec_nx;
            win    <= win_nx;
            // a/b follow the vector only while driving, so they read 0 in
            // IDLE and DONE without any output decode.
            a_q    <= (state_nx == DRIVE) ? vec_nx[1] : 1'b0;
            b_q    <= (state_nx == DRIVE) ? vec_nx[0] : 1'b0;
            err_q  <= err_nx;
            fv_q   <= fv_nx;
            seen_q <= seen_nx;
            pass_q <= pass_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        vec_nx   = vec;
        win_nx   = win;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = DRIVE;
                    vec_nx   = '0;
                    win_nx   = '0;
                end
            end
            DRIVE: begin
                if (win == WIN_LAST) begin
                    win_nx = '0;
                    if (vec == 2'b11) begin
                        state_nx = DONE;
                        vec_nx   = '0;
                    end else begin
                        vec_nx = vec + 2'd1;
                    end
                end else begin
                    win_nx = win + 4'd1;
                end
            end
            DONE: begin
`ifdef GATE_CHECKER_LOOP_EN
                // vec/win are already zero here, so a restart begins at 00.
                state_nx = start ? DRIVE : IDLE;
`else
                state_nx = IDLE;
`endif
            end
            default: begin
                state_nx = IDLE;
                vec_nx   = '0;
                win_nx   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Result bookkeeping
    // ------------------------------------------------------------------
    assign sample   = (state == DRIVE) && (win == WIN_LAST);
    assign mismatch = sample && (c != EXPECT[vec]);

    always_comb begin
        err_nx  = err_q;
        fv_nx   = fv_q;
        seen_nx = seen_q;
        pass_nx = pass_q;
        if ((state == IDLE) && start) begin
            err_nx  = '0;
            fv_nx   = '0;
            seen_nx = 1'b0;
        end else if (mismatch) begin
            err_nx = (err_q == 3'd7) ? 3'd7 : err_q + 3'd1;
            if (!seen_q) begin
                fv_nx   = vec;
                seen_nx = 1'b1;
            end
        end
        // The vector-11 sample lands on the same edge as DONE entry, so
        // pass must look at the updated count, not the registered one.
        if ((state == DRIVE) && (state_nx == DONE)) begin
            pass_nx = (err_nx == 3'd0);
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy     = (state == DRIVE);
        done     = (state == DONE);
        a        = a_q;
        b        = b_q;
        pass     = pass_q;
        err_cnt  = err_q;
        fail_vec = fv_q;
    end

endmodule

// File: tb/tb_gate_checker.sv
module tb_gate_checker;

    localparam int W  = 2;   // SETTLE+1 of the main instance
    localparam int W0 = 1;   // SETTLE+1 of the SETTLE=0 instance

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       s0_start = 1'b0;
    logic [1:0] mode = 2'd0;   // 0: XOR gate, 1: stuck-at-0, 2: OR gate

    logic       a, b, busy, done, pass, c;
    logic [2:0] err_cnt;
    logic [1:0] fail_vec;

    logic       s0_a, s0_b, s0_busy, s0_done, s0_pass, s0_c;
    logic [2:0] s0_err_cnt;
    logic [1:0] s0_fail_vec;

    typedef struct packed {
        logic [2:0] err;
        logic [1:0] fv;
        logic       pass;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // gate under test, selected by mode
    assign c    = (mode == 2'd0) ? (a ^ b)    : (mode == 2'd1) ? 1'b0 : (a | b);
    assign s0_c = (mode == 2'd0) ? (s0_a ^ s0_b) : (mode == 2'd1) ? 1'b0 : (s0_a | s0_b);

    gate_checker #(.SETTLE(1), .EXPECT(4'b0110)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .c(c),
        .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_vec(fail_vec)
    );

    gate_checker #(.SETTLE(0), .EXPECT(4'b0110)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(s0_start), .c(s0_c),
        .a(s0_a), .b(s0_b), .busy(s0_busy), .done(s0_done), .pass(s0_pass),
        .err_cnt(s0_err_cnt), .fail_vec(s0_fail_vec)
    );

    always #5 clk = ~clk;

    function automatic res_t mk(input logic [2:0] e, input logic [1:0] f, input logic p);
        res_t r;
        r.err  = e;
        r.fv   = f;
        r.pass = p;
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // start high for exactly one sampling edge; returns one negedge later
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({a, b, busy, done, pass, err_cnt, fail_vec} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_hold: got %b expected %b", {a, b, busy, done, pass, err_cnt, fail_vec}, 10'd0);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if ({a, b, busy, done, pass, err_cnt, fail_vec} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_idle: got %b expected %b", {a, b, busy, done, pass, err_cnt, fail_vec}, 10'd0);
        end
    endtask

    task automatic test_correct();
        res_t r;
        mode = 2'd0;
        exp_q.push_back(mk(3'd0, 2'b00, 1'b1));
        pulse_start();
        for (int k = 1; k <= 4 * W + 1; k++) begin
            logic [3:0] e;   // {busy,done,a,b}
            if (k <= 4 * W) e = {2'b10, 2'((k - 1) / W)};
            else            e = 4'b0100;
            n_cmp++;
            if ({busy, done, a, b} !== e) begin
                n_bad++;
                $display("FAIL correct_cycle%0d: got %b expected %b", k, {busy, done, a, b}, e);
            end
            if (k < 4 * W + 1) tick();
        end
        r = exp_q.pop_front();
        n_cmp++;
        if ({err_cnt, fail_vec, pass} !== r) begin
            n_bad++;
            $display("FAIL correct_result: got %b expected %b", {err_cnt, fail_vec, pass}, r);
        end
        tick();
    endtask

    task automatic test_idle_hold();
        repeat (5) tick();
        n_cmp++;
        if ({busy, done, a, b, err_cnt, fail_vec, pass} !== {4'b0000, 3'd0, 2'b00, 1'b1}) begin
            n_bad++;
            $display("FAIL idle_hold: got %b expected %b", {busy, done, a, b, err_cnt, fail_vec, pass},
                     {4'b0000, 3'd0, 2'b00, 1'b1});
        end
    endtask

    task automatic test_stuck0();
        res_t r;
        int   cyc;
        mode = 2'd1;
        exp_q.push_back(mk(3'd2, 2'b01, 1'b0));
        pulse_start();
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 4 * W) begin
            n_bad++;
            $display("FAIL stuck0_latency: got %0d expected %0d", cyc, 4 * W);
        end
        r = exp_q.pop_front();
        n_cmp++;
        if ({err_cnt, fail_vec, pass} !== r) begin
            n_bad++;
            $display("FAIL stuck0_result: got %b expected %b", {err_cnt, fail_vec, pass}, r);
        end
        repeat (2) tick();
    endtask

    task automatic test_wrong_gate();
        res_t r;
        int   cyc;
        mode = 2'd2;
        exp_q.push_back(mk(3'd1, 2'b11, 1'b0));
        pulse_start();
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 4 * W) begin
            n_bad++;
            $display("FAIL or_gate_latency: got %0d expected %0d", cyc, 4 * W);
        end
        r = exp_q.pop_front();
        n_cmp++;
        if ({err_cnt, fail_vec, pass} !== r) begin
            n_bad++;
            $display("FAIL or_gate_result: got %b expected %b", {err_cnt, fail_vec, pass}, r);
        end
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        res_t r;
        int   extra;
        mode = 2'd0;
        exp_q.push_back(mk(3'd0, 2'b00, 1'b1));
        pulse_start();
        for (int k = 1; k <= 4 * W + 1; k++) begin
            logic [3:0] e;
            if (k <= 4 * W) e = {2'b10, 2'((k - 1) / W)};
            else            e = 4'b0100;
            n_cmp++;
            if ({busy, done, a, b} !== e) begin
                n_bad++;
                $display("FAIL busy_start_cycle%0d: got %b expected %b", k, {busy, done, a, b}, e);
            end
            if (k == 3 || k == 8) start = 1'b1;
            if (k == 4 || k == 9) start = 1'b0;
            if (k < 4 * W + 1) tick();
        end
        r = exp_q.pop_front();
        n_cmp++;
        if ({err_cnt, fail_vec, pass} !== r) begin
            n_bad++;
            $display("FAIL busy_start_result: got %b expected %b", {err_cnt, fail_vec, pass}, r);
        end
        extra = 0;
        repeat (15) begin
            tick();
            if (done || busy) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL busy_start_no_rerun: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_mid_reset();
        res_t r;
        int   cyc;
        mode = 2'd0;
        pulse_start();               // this sequence is abandoned, no result expected
        repeat (2 * W) tick();       // first cycle of vector 10
        n_cmp++;
        if ({busy, a, b} !== 3'b110) begin
            n_bad++;
            $display("FAIL mid_reset_setup: got %b expected %b", {busy, a, b}, 3'b110);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a, b, busy, done, pass, err_cnt, fail_vec} !== 10'd0) begin
            n_bad++;
            $display("FAIL mid_reset_async: got %b expected %b", {a, b, busy, done, pass, err_cnt, fail_vec}, 10'd0);
        end
        tick();
        n_cmp++;
        if ({a, b, busy, done, pass, err_cnt, fail_vec} !== 10'd0) begin
            n_bad++;
            $display("FAIL mid_reset_held: got %b expected %b", {a, b, busy, done, pass, err_cnt, fail_vec}, 10'd0);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL mid_reset_waits_idle: got %b expected %b", {busy, done}, 2'b00);
        end
        exp_q.push_back(mk(3'd0, 2'b00, 1'b1));
        pulse_start();
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 4 * W) begin
            n_bad++;
            $display("FAIL mid_reset_rerun_latency: got %0d expected %0d", cyc, 4 * W);
        end
        r = exp_q.pop_front();
        n_cmp++;
        if ({err_cnt, fail_vec, pass} !== r) begin
            n_bad++;
            $display("FAIL mid_reset_rerun_result: got %b expected %b", {err_cnt, fail_vec, pass}, r);
        end
        repeat (2) tick();
    endtask

    task automatic test_settle0();
        res_t r;
        for (int m = 0; m < 2; m++) begin
            mode = 2'(m);
            if (m == 0) exp_q.push_back(mk(3'd0, 2'b00, 1'b1));
            else        exp_q.push_back(mk(3'd2, 2'b01, 1'b0));
            s0_start = 1'b1;
            tick();
            s0_start = 1'b0;
            for (int k = 1; k <= 4 * W0 + 1; k++) begin
                logic [3:0] e;
                if (k <= 4 * W0) e = {2'b10, 2'((k - 1) / W0)};
                else             e = 4'b0100;
                n_cmp++;
                if ({s0_busy, s0_done, s0_a, s0_b} !== e) begin
                    n_bad++;
                    $display("FAIL settle0_m%0d_cycle%0d: got %b expected %b", m, k,
                             {s0_busy, s0_done, s0_a, s0_b}, e);
                end
                if (k < 4 * W0 + 1) tick();
            end
            r = exp_q.pop_front();
            n_cmp++;
            if ({s0_err_cnt, s0_fail_vec, s0_pass} !== r) begin
                n_bad++;
                $display("FAIL settle0_m%0d_result: got %b expected %b", m,
                         {s0_err_cnt, s0_fail_vec, s0_pass}, r);
            end
            repeat (2) tick();
        end
    endtask

`ifdef GATE_CHECKER_LOOP_EN
    task automatic test_loop();
        res_t r;
        int   cyc;
        mode = 2'd1;
        exp_q.push_back(mk(3'd2, 2'b01, 1'b0));
        exp_q.push_back(mk(3'd4, 2'b01, 1'b0));
        exp_q.push_back(mk(3'd6, 2'b01, 1'b0));
        exp_q.push_back(mk(3'd7, 2'b01, 1'b0));
        exp_q.push_back(mk(3'd7, 2'b01, 1'b0));
        start = 1'b1;
        for (int n = 0; n < 5; n++) begin
            wait_done(cyc);
            n_cmp++;
            if (cyc !== 4 * W + 1) begin
                n_bad++;
                $display("FAIL loop%0d_period: got %0d expected %0d", n, cyc, 4 * W + 1);
            end
            r = exp_q.pop_front();
            n_cmp++;
            if ({err_cnt, fail_vec, pass} !== r) begin
                n_bad++;
                $display("FAIL loop%0d_result: got %b expected %b", n, {err_cnt, fail_vec, pass}, r);
            end
        end
        start = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL loop_exit: got %b expected %b", {busy, done}, 2'b00);
        end
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_correct();
        test_idle_hold();
        test_stuck0();
        test_wrong_gate();
        test_back_to_back();
        test_mid_reset();
        test_settle0();
`ifdef GATE_CHECKER_LOOP_EN
        test_loop();
`endif
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
